// File: rtl/block_sync_pkg.sv
// Shared definitions for the multilane 66b sync-header block-lock engine:
// lane state encodings and the IEEE 802.3 default geometry and limits.
package block_sync_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b10,
    ST_LOCKED   = 2'b01
  } state_e;

  localparam int DEF_NB_CODED_BLOCK  = 66;
  localparam int DEF_MAX_INDEX_VALUE = DEF_NB_CODED_BLOCK - 2;

  localparam int DEF_UNLOCKED_WINDOW = 64;
  localparam int DEF_LOCKED_WINDOW   = 1024;
  localparam int DEF_SH_INVALID      = 65;

endpackage : block_sync_pkg

// File: rtl/block_sync_lane.sv
// One PCS lane: searches for a stable 01/10 sync-header alignment, locks onto
// it, and monitors per-window invalid headers, slipping by one on lock loss.
module block_sync_lane
  import block_sync_pkg::*;
#(
  parameter int NB_CODED_BLOCK  = DEF_NB_CODED_BLOCK,
  parameter int MAX_INDEX_VALUE = NB_CODED_BLOCK - 2,
  parameter int NB_WINDOW_CNT   = 12,
  parameter int NB_INVALID_CNT  = 8,
  parameter int NB_INDEX        = $clog2(NB_CODED_BLOCK)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_tick,
  input  logic                      i_signal_ok,
  input  logic                      i_sh_valid,
  input  logic [NB_WINDOW_CNT-1:0]  i_unlocked_window_limit,
  input  logic [NB_WINDOW_CNT-1:0]  i_locked_window_limit,
  input  logic [NB_INVALID_CNT-1:0] i_sh_invalid_limit,
  output logic [NB_INDEX-1:0]       o_block_index,
  output logic [NB_INDEX-1:0]       o_search_index,
  output logic                      o_block_lock,
  output logic                      o_lock_lost
);

  state_e                    state_q, state_d;
  logic [NB_WINDOW_CNT-1:0]  win_q, win_d;
  logic [NB_INVALID_CNT-1:0] inv_q, inv_d;
  logic [NB_INDEX-1:0]       search_q, search_d;
  logic [NB_INDEX-1:0]       block_q, block_d;
  logic                      lost_q, lost_d;

  logic [NB_WINDOW_CNT-1:0]  unlocked_last;
  logic [NB_WINDOW_CNT-1:0]  locked_last;
  logic [NB_INVALID_CNT-1:0] inv_limit;
  logic [NB_INVALID_CNT-1:0] inv_next;

  function automatic logic [NB_INDEX-1:0] next_index(input logic [NB_INDEX-1:0] idx);
    return (idx == NB_INDEX'(MAX_INDEX_VALUE)) ? '0 : idx + 1'b1;
  endfunction

  // A programmed limit of 0 behaves as 1, so the terminal count saturates at 0.
  assign unlocked_last = (i_unlocked_window_limit == '0) ? '0 : i_unlocked_window_limit - 1'b1;
  assign locked_last   = (i_locked_window_limit == '0) ? '0 : i_locked_window_limit - 1'b1;
  assign inv_limit     = (i_sh_invalid_limit == '0) ? NB_INVALID_CNT'(1) : i_sh_invalid_limit;
  assign inv_next      = inv_q + {{(NB_INVALID_CNT-1){1'b0}}, ~i_sh_valid};

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    win_d    = win_q;
    inv_d    = inv_q;
    search_d = search_q;
    block_d  = block_q;
    lost_d   = 1'b0;
    if (i_tick) begin
      if (!i_signal_ok) begin
        state_d  = ST_UNLOCKED;
        win_d    = '0;
        inv_d    = '0;
        search_d = '0;
        block_d  = '0;
        lost_d   = (state_q == ST_LOCKED);
      end else begin
        case (state_q)
          ST_UNLOCKED: begin
            if (!i_sh_valid) begin
              search_d = next_index(search_q);
              win_d    = '0;
            end else if (win_q == unlocked_last) begin
              block_d = search_q;
              state_d = ST_LOCKED;
              win_d   = '0;
              inv_d   = '0;
            end else begin
              win_d = win_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            // Threshold is tested before window end so a coincident hit still drops lock.
            if (inv_next >= inv_limit) begin
              state_d  = ST_UNLOCKED;
              search_d = next_index(block_q);
              win_d    = '0;
              inv_d    = '0;
              lost_d   = 1'b1;
            end else if (win_q == locked_last) begin
              win_d = '0;
              inv_d = '0;
            end else begin
              win_d = win_q + 1'b1;
              inv_d = inv_next;
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end
  end

  // NOTE: reset is synchronous and active-high, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q  <= ST_UNLOCKED;
      win_q    <= '0;
      inv_q    <= '0;
      search_q <= '0;
      block_q  <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      inv_q    <= inv_d;
      search_q <= search_d;
      block_q  <= block_d;
      lost_q   <= lost_d;
    end
  end

  assign o_block_index  = block_q;
  assign o_search_index = search_q;
  assign o_block_lock   = (state_q == ST_LOCKED);
  assign o_lock_lost    = lost_q;

endmodule : block_sync_lane

// File: rtl/block_sync_multilane.sv
// N_LANES independent block-lock engines sharing one tick and limit set, with
// packed per-lane index buses and a registered all-lanes-locked flag.
module block_sync_multilane
  import block_sync_pkg::*;
#(
  parameter int N_LANES         = 20,
  parameter int NB_CODED_BLOCK  = DEF_NB_CODED_BLOCK,
  parameter int MAX_INDEX_VALUE = NB_CODED_BLOCK - 2,
  parameter int MAX_WINDOW      = 2048,
  parameter int MAX_INVALID_SH  = 127,
  parameter int NB_WINDOW_CNT   = $clog2(MAX_WINDOW) + 1,
  parameter int NB_INVALID_CNT  = $clog2(MAX_INVALID_SH) + 1,
  parameter int NB_INDEX        = $clog2(NB_CODED_BLOCK)
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_valid,
  input  logic [N_LANES-1:0]          i_signal_ok,
  input  logic [N_LANES-1:0]          i_sh_valid,
  input  logic [NB_WINDOW_CNT-1:0]    i_unlocked_window_limit,
  input  logic [NB_WINDOW_CNT-1:0]    i_locked_window_limit,
  input  logic [NB_INVALID_CNT-1:0]   i_sh_invalid_limit,
  output logic [N_LANES*NB_INDEX-1:0] o_block_index,
  output logic [N_LANES*NB_INDEX-1:0] o_search_index,
  output logic [N_LANES-1:0]          o_block_lock,
  output logic [N_LANES-1:0]          o_lock_lost,
  output logic                        o_all_locked
);

  logic tick;
  logic all_locked_q;

  assign tick = i_enable & i_valid;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    block_sync_lane #(
      .NB_CODED_BLOCK  (NB_CODED_BLOCK),
      .MAX_INDEX_VALUE (MAX_INDEX_VALUE),
      .NB_WINDOW_CNT   (NB_WINDOW_CNT),
      .NB_INVALID_CNT  (NB_INVALID_CNT),
      .NB_INDEX        (NB_INDEX)
    ) u_lane (
      .i_clock                 (i_clock),
      .i_reset                 (i_reset),
      .i_tick                  (tick),
      .i_signal_ok             (i_signal_ok[k]),
      .i_sh_valid              (i_sh_valid[k]),
      .i_unlocked_window_limit (i_unlocked_window_limit),
      .i_locked_window_limit   (i_locked_window_limit),
      .i_sh_invalid_limit      (i_sh_invalid_limit),
      .o_block_index           (o_block_index[k*NB_INDEX +: NB_INDEX]),
      .o_search_index          (o_search_index[k*NB_INDEX +: NB_INDEX]),
      .o_block_lock            (o_block_lock[k]),
      .o_lock_lost             (o_lock_lost[k])
    );
  end

  // Registered off the lane lock flags, so it trails them by one cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= &o_block_lock;
    end
  end

  assign o_all_locked = all_locked_q;

endmodule : block_sync_multilane

// File: tb/tb_block_sync_multilane.sv
// Scoreboard bench: directed phases push hand-computed expectations tagged
// with a cycle number; a negedge monitor pops and compares them.
module tb_block_sync_multilane;
  import block_sync_pkg::*;

  localparam int N     = 4;
  localparam int NBW   = 12;
  localparam int NBI_C = 8;
  localparam int NBI   = 7;

  typedef enum int {F_BIDX, F_SIDX, F_LOCK, F_LOST, F_ALL} fld_e;

  typedef struct {
    int    cyc;
    string name;
    fld_e  fld;
    int    lane;
    int    val;
  } exp_t;

  logic               clk = 1'b0;
  logic               i_reset, i_enable, i_valid;
  logic [N-1:0]       i_signal_ok, i_sh_valid;
  logic [NBW-1:0]     i_unlocked_window_limit, i_locked_window_limit;
  logic [NBI_C-1:0]   i_sh_invalid_limit;
  logic [N*NBI-1:0]   o_block_index, o_search_index;
  logic [N-1:0]       o_block_lock, o_lock_lost;
  logic               o_all_locked;

  exp_t   exp_q[$];
  int     cyc_cnt = 0;
  int     n_cmp   = 0;
  int     n_bad   = 0;
  int     target[N];
  logic [N-1:0] force_inv;

  block_sync_multilane #(.N_LANES(N)) dut (
    .i_clock                 (clk),
    .i_reset                 (i_reset),
    .i_enable                (i_enable),
    .i_valid                 (i_valid),
    .i_signal_ok             (i_signal_ok),
    .i_sh_valid              (i_sh_valid),
    .i_unlocked_window_limit (i_unlocked_window_limit),
    .i_locked_window_limit   (i_locked_window_limit),
    .i_sh_invalid_limit      (i_sh_invalid_limit),
    .o_block_index           (o_block_index),
    .o_search_index          (o_search_index),
    .o_block_lock            (o_block_lock),
    .o_lock_lost             (o_lock_lost),
    .o_all_locked            (o_all_locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int actual(fld_e f, int lane);
    case (f)
      F_BIDX:  return int'(o_block_index[lane*NBI +: NBI]);
      F_SIDX:  return int'(o_search_index[lane*NBI +: NBI]);
      F_LOCK:  return int'(o_block_lock);
      F_LOST:  return int'(o_lock_lost);
      default: return int'(o_all_locked);
    endcase
  endfunction

  // Monitor: compares every expectation whose cycle tag is the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      int   a;
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc < cyc_cnt) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc_cnt);
      end else begin
        a = actual(e.fld, e.lane);
        if (a !== e.val) begin
          n_bad++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc_cnt);
        end
      end
    end
  end

  task automatic expect_now(input string name, input fld_e f, input int lane, input int val);
    exp_t e;
    e.cyc = cyc_cnt; e.name = name; e.fld = f; e.lane = lane; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Emulates the data selector: a header is valid when the lane's current
  // alignment matches its true block boundary and no error is being injected.
  task automatic run(input int n, input logic [N-1:0] finv);
    logic [N-1:0] sh;
    int cur;
    force_inv = finv;
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < N; k++) begin
        cur = o_block_lock[k] ? int'(o_block_index[k*NBI +: NBI]) : int'(o_search_index[k*NBI +: NBI]);
        sh[k] = (cur == target[k]) && !force_inv[k];
      end
      i_sh_valid = sh;
      i_valid    = 1'b1;
      step(1);
    end
  endtask

  task automatic do_reset();
    i_reset     = 1'b1;
    i_valid     = 1'b0;
    i_sh_valid  = '0;
    i_signal_ok = '1;
    step(2);
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0;
    i_signal_ok = '1; i_sh_valid = '0; force_inv = '0;
    i_unlocked_window_limit = NBW'(8);
    i_locked_window_limit   = NBW'(16);
    i_sh_invalid_limit      = NBI_C'(3);
    target = '{5, 127, 127, 127};

    step(2);
    expect_now("rst_lock", F_LOCK, 0, 0);
    expect_now("rst_lost", F_LOST, 0, 0);
    expect_now("rst_all",  F_ALL,  0, 0);
    expect_now("rst_sidx0", F_SIDX, 0, 0);
    expect_now("rst_bidx0", F_BIDX, 0, 0);
    i_reset = 1'b0;

    // Acquire: 5 invalid then 8 valid ticks on lane 0.
    run(12, '0);
    expect_now("acq_pre_lock", F_LOCK, 0, 0);
    expect_now("acq_pre_sidx0", F_SIDX, 0, 5);
    run(1, '0);
    expect_now("acq_lock", F_LOCK, 0, 4'b0001);
    expect_now("acq_bidx0", F_BIDX, 0, 5);
    expect_now("acq_sidx1", F_SIDX, 1, 13);
    expect_now("acq_all", F_ALL, 0, 0);

    // Two invalids per window, straddling the first boundary.
    run(14, '0);
    run(2, 4'b0001);
    run(2, 4'b0001);
    expect_now("win_edge_lock", F_LOCK, 0, 4'b0001);
    run(21, '0);
    run(2, 4'b0001);
    run(7, '0);
    expect_now("win_hold_lock", F_LOCK, 0, 4'b0001);
    expect_now("win_hold_lost", F_LOST, 0, 0);
    expect_now("win_hold_bidx0", F_BIDX, 0, 5);

    // Reset mid-window while locked: no lock-lost pulse.
    run(3, '0);
    run(2, 4'b0001);
    i_reset = 1'b1;
    step(1);
    expect_now("midrst_lock", F_LOCK, 0, 0);
    expect_now("midrst_lost", F_LOST, 0, 0);
    expect_now("midrst_bidx0", F_BIDX, 0, 0);
    step(1);
    i_reset = 1'b0;

    // Lock at 63, lose it, slip to 64, then wrap to 0.
    target = '{63, 127, 127, 127};
    do_reset();
    run(71, '0);
    expect_now("slip_lock", F_LOCK, 0, 4'b0001);
    expect_now("slip_bidx0", F_BIDX, 0, 63);
    run(2, 4'b0001);
    expect_now("slip_pre_lock", F_LOCK, 0, 4'b0001);
    run(1, 4'b0001);
    expect_now("slip_unlock", F_LOCK, 0, 0);
    expect_now("slip_lost", F_LOST, 0, 4'b0001);
    expect_now("slip_sidx0", F_SIDX, 0, 64);
    expect_now("slip_bidx_hold", F_BIDX, 0, 63);
    run(1, '0);
    expect_now("wrap_sidx0", F_SIDX, 0, 0);
    expect_now("wrap_lost_clr", F_LOST, 0, 0);

    // Third invalid lands on the 16th tick of the window.
    target = '{5, 127, 127, 127};
    do_reset();
    run(13, '0);
    run(3, '0);
    run(1, 4'b0001);
    run(5, '0);
    run(1, 4'b0001);
    run(5, '0);
    expect_now("coin_pre_lock", F_LOCK, 0, 4'b0001);
    run(1, 4'b0001);
    expect_now("coin_unlock", F_LOCK, 0, 0);
    expect_now("coin_lost", F_LOST, 0, 4'b0001);
    expect_now("coin_sidx0", F_SIDX, 0, 6);

    // Aggregate lock, idle gaps and a signal_ok drop.
    target = '{5, 10, 2, 20};
    do_reset();
    run(15, '0);
    expect_now("agg_mid_lock", F_LOCK, 0, 4'b0101);
    i_valid = 1'b0;
    step(4);
    i_valid = 1'b1; i_enable = 1'b0;
    step(2);
    i_enable = 1'b1;
    expect_now("gap_lock", F_LOCK, 0, 4'b0101);
    expect_now("gap_sidx1", F_SIDX, 1, 10);
    expect_now("gap_sidx3", F_SIDX, 3, 15);
    expect_now("gap_bidx2", F_BIDX, 2, 2);
    run(13, '0);
    expect_now("agg_lock", F_LOCK, 0, 4'b1111);
    expect_now("agg_all_lag", F_ALL, 0, 0);
    expect_now("agg_bidx3", F_BIDX, 3, 20);
    run(1, '0);
    expect_now("agg_all", F_ALL, 0, 1);
    i_signal_ok = 4'b1011;
    run(1, '0);
    expect_now("sok_lock", F_LOCK, 0, 4'b1011);
    expect_now("sok_lost", F_LOST, 0, 4'b0100);
    expect_now("sok_sidx2", F_SIDX, 2, 0);
    expect_now("sok_bidx2", F_BIDX, 2, 0);
    run(1, '0);
    expect_now("sok_all", F_ALL, 0, 0);
    expect_now("sok_lost_clr", F_LOST, 0, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) step(1);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_block_sync_multilane
